mux4_scan_seq: RTL and testbench

- Upstream sequencer for the 4:1 mux stage: snapshots a 4-bit word plus a channel-enable mask, then drives the mux data bus D and select Sel.
- Walks Sel through the enabled channels in ascending order, holding each select for a programmable dwell time.
- Flags valid selects to the consumer and signals completion of each scan.

---
 rtl/mux4_scan_seq.sv | 116 +++++++++++
 tb/tb_mux4_scan_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_scan_seq.sv
// Scan sequencer for the 4:1 mux: snapshots D and walks Sel over enabled channels.
// Optional MUX4_SCAN_LOOP_EN adds STOP for back-to-back rescans without an IDLE gap.
module mux4_scan_seq #(
    parameter int DWELL = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] D_IN,
    input  logic [3:0] CH_MASK,
`ifdef MUX4_SCAN_LOOP_EN
    input  logic       STOP,
`endif
    output logic [3:0] D,
    output logic [1:0] Sel,
    output logic       SEL_VALID,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] mask;
    logic [2:0] fst;
    logic [2:0] nxt;
    logic       loop_go;
    logic       accept;

    // {found, index} of the lowest set bit at or above lo
    function automatic logic [2:0] first_from(input logic [3:0] m,
                                              input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign fst = first_from(CH_MASK, 3'd0);
    assign nxt = first_from(mask, {1'b0, Sel} + 3'd1);

`ifdef MUX4_SCAN_LOOP_EN
    assign loop_go = ~STOP;
`else
    assign loop_go = 1'b0;
`endif

    assign accept = ((state == S_IDLE) && START) ||
                    ((state == S_DONE) && loop_go);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            D         <= 4'b0000;
            Sel       <= 2'b00;
            SEL_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            cnt       <= 8'd0;
            mask      <= 4'b0000;
        end else if (accept) begin
            D    <= D_IN;
            mask <= CH_MASK;
            cnt  <= 8'd0;
            BUSY <= 1'b1;
            if (fst[2]) begin
                Sel       <= fst[1:0];
                SEL_VALID <= 1'b1;
                DONE      <= 1'b0;
                state     <= S_SCAN;
            end else begin
                SEL_VALID <= 1'b0;
                DONE      <= 1'b1;
                state     <= S_DONE;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    SEL_VALID <= 1'b0;
                    BUSY      <= 1'b0;
                    DONE      <= 1'b0;
                end
                S_SCAN: begin
                    if (cnt == LAST) begin
                        cnt <= 8'd0;
                        if (nxt[2]) begin
                            Sel <= nxt[1:0];
                        end else begin
                            SEL_VALID <= 1'b0;
                            DONE      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_scan_seq.sv
// Directed bench for mux4_scan_seq with DWELL=2 and DWELL=3 instances.
// Loop-mode steps are compiled in only with MUX4_SCAN_LOOP_EN.
module tb_mux4_scan_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [3:0] D_IN = 4'b0000;
    logic [3:0] CH_MASK = 4'b0000;
`ifdef MUX4_SCAN_LOOP_EN
    logic       STOP = 1'b1;
`endif

    logic [3:0] d2, d3;
    logic [1:0] s2, s3;
    logic       v2, v3, b2, b3, f2, f3;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mux4_scan_seq #(.DWELL(2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .D_IN(D_IN), .CH_MASK(CH_MASK),
`ifdef MUX4_SCAN_LOOP_EN
        .STOP(STOP),
`endif
        .D(d2), .Sel(s2), .SEL_VALID(v2), .BUSY(b2), .DONE(f2)
    );

    mux4_scan_seq #(.DWELL(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(START), .D_IN(D_IN), .CH_MASK(CH_MASK),
`ifdef MUX4_SCAN_LOOP_EN
        .STOP(STOP),
`endif
        .D(d3), .Sel(s3), .SEL_VALID(v3), .BUSY(b3), .DONE(f3)
    );

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // expected {D, Sel, SEL_VALID, BUSY, DONE}
    task automatic e2(input string tag, input logic [3:0] ed, input logic [1:0] es,
                      input logic ev, input logic eb, input logic ef);
        chk(tag, {d2, s2, v2, b2, f2}, {ed, es, ev, eb, ef});
    endtask

    task automatic e3(input string tag, input logic [3:0] ed, input logic [1:0] es,
                      input logic ev, input logic eb, input logic ef);
        chk(tag, {d3, s3, v3, b3, f3}, {ed, es, ev, eb, ef});
    endtask

    initial begin
        logic [3:0] pat;
        logic [1:0] es;

        // reset then idle
        #1;
        e2("reset", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        e3("reset3", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            e2("idle", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // full scan, DWELL=2
        pat = 4'b1010;
        D_IN = pat;
        CH_MASK = 4'b1111;
        START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            START = 1'b0;
            es = 2'(i / 2);
            e2("full_scan", pat, es, 1'b1, 1'b1, 1'b0);
            chk("full_y", {8'd0, d2[s2]}, {8'd0, pat[es]});
        end
        @(negedge CLK);
        e2("full_done", pat, 2'd3, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e2("full_idle", pat, 2'd3, 1'b0, 1'b0, 1'b0);

        // interference during a scan
        START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            START = (i % 2 == 0) && (i < 6);
            D_IN = 4'b0101;
            CH_MASK = 4'b0001;
            e2("intf_scan", pat, 2'(i / 2), 1'b1, 1'b1, 1'b0);
        end
        START = 1'b0;
        @(negedge CLK);
        e2("intf_done", pat, 2'd3, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e2("intf_idle", pat, 2'd3, 1'b0, 1'b0, 1'b0);

        // mid-scan reset
        D_IN = 4'b1010;
        CH_MASK = 4'b1111;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        e2("mid_scan0", 4'b1010, 2'd0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("mid_scan1", 4'b1010, 2'd0, 1'b1, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        e2("mid_rst_async", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            e2("post_rst", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // empty mask
        CH_MASK = 4'b0000;
        D_IN = 4'b0110;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        e2("empty_done", 4'b0110, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e2("empty_idle", 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0);

        // START held high: one idle cycle between scans
        CH_MASK = 4'b0100;
        D_IN = 4'b1111;
        START = 1'b1;
        @(negedge CLK);
        e2("hold_v0", 4'hf, 2'd2, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("hold_v1", 4'hf, 2'd2, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("hold_done", 4'hf, 2'd2, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e2("hold_gap", 4'hf, 2'd2, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        e2("hold_v2", 4'hf, 2'd2, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("hold_v3", 4'hf, 2'd2, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("hold_done2", 4'hf, 2'd2, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e2("hold_idle", 4'hf, 2'd2, 1'b0, 1'b0, 1'b0);

        // sparse mask on the DWELL=3 instance
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        pat = 4'b1001;
        D_IN = pat;
        CH_MASK = 4'b1001;
        START = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            START = 1'b0;
            es = (i < 3) ? 2'd0 : 2'd3;
            e3("sparse_scan", pat, es, 1'b1, 1'b1, 1'b0);
            chk("sparse_y", {8'd0, d3[s3]}, {8'd0, pat[es]});
        end
        @(negedge CLK);
        e3("sparse_done", pat, 2'd3, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e3("sparse_idle", pat, 2'd3, 1'b0, 1'b0, 1'b0);

`ifdef MUX4_SCAN_LOOP_EN
        // looped scans with STOP low, then STOP high
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        STOP = 1'b0;
        CH_MASK = 4'b0001;
        D_IN = 4'b0011;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        D_IN = 4'b1100;
        e2("loop_a0", 4'b0011, 2'd0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("loop_a1", 4'b0011, 2'd0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("loop_done1", 4'b0011, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        STOP = 1'b1;
        e2("loop_b0", 4'b1100, 2'd0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("loop_b1", 4'b1100, 2'd0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        e2("loop_done2", 4'b1100, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        e2("loop_idle", 4'b1100, 2'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
